// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one SDRAM ROM read port among CHANNELS requesters.
// Ports:
//   clk_sys, reset            clock and async active-high reset
//   ch_req/ch_addr            per-channel request pulse and address
//   ch_dout/ch_rdy            per-channel read data and completion pulse
//   ch_overrun                per-channel sticky dropped-request flag
//   mem_req/mem_addr/mem_ch   memory transaction start, address, channel
//   mem_ack/mem_dout          memory completion pulse and read data
//   busy                      transaction outstanding (ISSUE or WAIT)
module rom_port_arbiter #(
  parameter int CHANNELS  = 4,
  parameter int AW        = 18,
  parameter int DW        = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           ch_req,
  input  logic [CHANNELS*AW-1:0]        ch_addr,
  output logic [CHANNELS*DW-1:0]        ch_dout,
  output logic [CHANNELS-1:0]           ch_rdy,
  output logic [CHANNELS-1:0]           ch_overrun,
  output logic                          mem_req,
  output logic [AW-1:0]                 mem_addr,
  output logic [$clog2(CHANNELS)-1:0]   mem_ch,
  input  logic                          mem_ack,
  input  logic [DW-1:0]                 mem_dout,
  output logic                          busy
);
  localparam int CW = $clog2(CHANNELS);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  logic [1:0]             r_state;
  logic [CHANNELS-1:0]    r_pending;
  logic [CHANNELS-1:0]    r_rdy;
  logic [CHANNELS-1:0]    r_overrun;
  logic [AW-1:0]          r_addr [CHANNELS];
  logic [CHANNELS*DW-1:0] r_dout;
  logic [AW-1:0]          r_mem_addr;
  logic [CW-1:0]          r_mem_ch;
  logic [CW-1:0]          r_last;
  logic [CW-1:0]          w_win;
  logic [CW-1:0]          w_idx;
  logic                   w_grant;
  // Scan from the farthest candidate to the nearest so the nearest pending
  // channel overwrites the others: last_grant+1 first for round-robin,
  // index 0 first for fixed priority.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      w_idx = (FIXED_PRI != 0) ? CW'(i - 1)
                               : CW'(({1'b0, r_last} + (CW+1)'(i)) % (CW+1)'(CHANNELS));
      if (r_pending[w_idx]) w_win = w_idx;
    end
  end
  assign w_grant = (r_state == IDLE) && (|r_pending);
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_rdy      <= '0;
      r_overrun  <= '0;
      r_dout     <= '0;
      r_mem_addr <= '0;
      r_mem_ch   <= '0;
      r_last     <= CW'(CHANNELS - 1);
      for (int n = 0; n < CHANNELS; n++) r_addr[n] <= '0;
    end else begin
      // A request landing in the cycle its own pending bit is granted away
      // is a fresh request, not an overrun.
      for (int n = 0; n < CHANNELS; n++) begin
        if (ch_req[n] && (!r_pending[n] || (w_grant && w_win == CW'(n)))) begin
          r_pending[n] <= 1'b1;
          r_addr[n]    <= ch_addr[n*AW +: AW];
        end else if (ch_req[n]) begin
          r_overrun[n] <= 1'b1;
        end else if (w_grant && w_win == CW'(n)) begin
          r_pending[n] <= 1'b0;
        end
      end
      r_rdy <= '0;
      if (w_grant) begin
        r_state    <= ISSUE;
        r_mem_addr <= r_addr[w_win];
        r_mem_ch   <= w_win;
        r_last     <= w_win;
      end else if (r_state == ISSUE) begin
        r_state <= WAIT;
      end else if (r_state == WAIT && mem_ack) begin
        r_state                   <= IDLE;
        r_dout[r_mem_ch*DW +: DW] <= mem_dout;
        r_rdy[r_mem_ch]           <= 1'b1;
      end
    end
  end
  assign ch_dout    = r_dout;
  assign ch_rdy     = r_rdy;
  assign ch_overrun = r_overrun;
  assign mem_req    = (r_state == ISSUE);
  assign mem_addr   = r_mem_addr;
  assign mem_ch     = r_mem_ch;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed scoreboard bench for rom_port_arbiter.
module tb_rom_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic           reset;
  logic [N-1:0]   ch_req, ch_rdy, ch_overrun;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_dout;
  logic           mem_req, mem_ack, busy;
  logic [AW-1:0]  mem_addr;
  logic [1:0]     mem_ch;
  logic [DW-1:0]  mem_dout;
  logic [N-1:0]   f_req, f_rdy, f_overrun;
  logic [N*AW-1:0] f_addr;
  logic [N*DW-1:0] f_dout_ch;
  logic           f_mem_req, f_ack, f_busy;
  logic [AW-1:0]  f_mem_addr;
  logic [1:0]     f_mem_ch;
  logic [DW-1:0]  f_dout;
  rom_port_arbiter #(.CHANNELS(N), .AW(AW), .DW(DW), .FIXED_PRI(0)) u_rr (
    .clk_sys(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_dout(ch_dout), .ch_rdy(ch_rdy), .ch_overrun(ch_overrun),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ch(mem_ch),
    .mem_ack(mem_ack), .mem_dout(mem_dout), .busy(busy));
  rom_port_arbiter #(.CHANNELS(N), .AW(AW), .DW(DW), .FIXED_PRI(1)) u_fp (
    .clk_sys(clk), .reset(reset), .ch_req(f_req), .ch_addr(f_addr),
    .ch_dout(f_dout_ch), .ch_rdy(f_rdy), .ch_overrun(f_overrun),
    .mem_req(f_mem_req), .mem_addr(f_mem_addr), .mem_ch(f_mem_ch),
    .mem_ack(f_ack), .mem_dout(f_dout), .busy(f_busy));
  typedef struct {int ch; logic [AW-1:0] addr;} req_t;
  req_t q[$];
  logic [DW-1:0] exp_dout [N];
  int errors = 0;
  int checks = 0;
  int cur_ch = 0;
  int n;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_dout();
    for (int i = 0; i < N; i++) chk($sformatf("dout%0d", i), 64'(ch_dout[i*DW +: DW]), 64'(exp_dout[i]));
  endtask
  task automatic do_reset();
    reset = 1'b1; ch_req = '0; mem_ack = 1'b0; f_req = '0; f_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) exp_dout[i] = '0;
    q.delete();
  endtask
  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    ch_addr[ch*AW +: AW] = a;
  endtask
  task automatic push(input int ch, input logic [AW-1:0] a);
    req_t r;
    r.ch = ch; r.addr = a;
    q.push_back(r);
  endtask
  task automatic pulse(input logic [N-1:0] m);
    ch_req = m;
    tick();
    ch_req = '0;
  endtask
  task automatic wait_req(input int exp_wait);
    int w;
    req_t r;
    w = 0;
    while (!mem_req && w < 20) begin tick(); w++; end
    chk("req_seen", 64'(mem_req), 64'd1);
    if (exp_wait >= 0) chk("req_latency", 64'(w), 64'(exp_wait));
    if (q.size() == 0) begin
      checks++; errors++;
      $error("FAIL sb_empty observed=mem_req expected=no_request");
    end else begin
      r = q.pop_front();
      chk("mem_ch", 64'(mem_ch), 64'(r.ch));
      chk("mem_addr", 64'(mem_addr), 64'(r.addr));
      cur_ch = r.ch;
    end
    chk("busy_issue", 64'(busy), 64'd1);
  endtask
  task automatic ack(input int d, input logic [DW-1:0] data);
    repeat (d) tick();
    mem_ack = 1'b1; mem_dout = data;
    tick();
    mem_ack = 1'b0;
    chk("rdy", 64'(ch_rdy), 64'd1 << cur_ch);
    chk("busy_done", 64'(busy), 64'd0);
    exp_dout[cur_ch] = data;
    chk_dout();
  endtask
  initial begin
    ch_addr = '0; f_addr = '0; mem_dout = '0; f_dout = '0;
    do_reset();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_ch", 64'(mem_ch), 64'd0);
    chk("rst_rdy", 64'(ch_rdy), 64'd0);
    chk("rst_overrun", 64'(ch_overrun), 64'd0);
    chk_dout();
    // fixed priority: channel 0 re-requests during each WAIT and starves channel 3
    f_addr[0 +: AW] = 18'h100; f_addr[3*AW +: AW] = 18'h300;
    f_req = 4'b1001;
    tick();
    f_req = '0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!f_mem_req && n < 20) begin tick(); n++; end
      chk("fp_grant", 64'(f_mem_ch), (k < 3) ? 64'd0 : 64'd3);
      chk("fp_addr", 64'(f_mem_addr), (k < 3) ? 64'h100 : 64'h300);
      tick();
      f_ack = 1'b1; f_dout = 32'(k);
      if (k < 2) f_req = 4'b0001;
      tick();
      f_ack = 1'b0; f_req = '0;
      chk("fp_rdy", 64'(f_rdy), (k < 3) ? 64'd1 : 64'd8);
    end
    chk("fp_overrun", 64'(f_overrun), 64'd0);
    // single request
    do_reset();
    set_addr(2, 18'h1234); push(2, 18'h1234);
    pulse(4'b0100);
    chk("single_idle_busy", 64'(busy), 64'd0);
    wait_req(1);
    ack(3, 32'hDEADBEEF);
    // round-robin bursts
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        set_addr(i, 18'(16 * b + 16 + i));
        push(i, 18'(16 * b + 16 + i));
      end
      pulse(4'hF);
      for (int i = 0; i < N; i++) begin
        wait_req(1);
        ack(1, 32'hA000_0000 + 32'(16 * b + i));
      end
    end
    // overrun: second request for channel 1 while it is pending
    set_addr(0, 18'h2A); set_addr(1, 18'h111);
    push(0, 18'h2A); push(1, 18'h111);
    pulse(4'b0011);
    set_addr(1, 18'h222);
    pulse(4'b0010);
    wait_req(-1);
    ack(1, 32'h0000_C0DE);
    wait_req(1);
    ack(1, 32'h1111_1111);
    chk("overrun1", 64'(ch_overrun), 64'b0010);
    // re-request on the grant cycle
    set_addr(0, 18'h0B0); push(0, 18'h0B0);
    pulse(4'b0001);
    set_addr(0, 18'h0C0); push(0, 18'h0C0);
    pulse(4'b0001);
    wait_req(-1);
    ack(1, 32'hB0B0_B0B0);
    wait_req(1);
    ack(1, 32'hC0C0_C0C0);
    chk("regrant_overrun", 64'(ch_overrun), 64'b0010);
    // ack in IDLE and in ISSUE are ignored
    mem_ack = 1'b1; mem_dout = 32'hBAD0_0001;
    tick();
    mem_ack = 1'b0;
    chk("ack_idle_rdy", 64'(ch_rdy), 64'd0);
    chk_dout();
    set_addr(3, 18'h3D3); push(3, 18'h3D3);
    pulse(4'b1000);
    wait_req(1);
    mem_ack = 1'b1; mem_dout = 32'hBAD0_0002;
    tick();
    mem_ack = 1'b0;
    chk("ack_issue_rdy", 64'(ch_rdy), 64'd0);
    chk("ack_issue_busy", 64'(busy), 64'd1);
    chk_dout();
    ack(0, 32'h3333_3333);
    // reset during WAIT
    set_addr(1, 18'h3C); push(1, 18'h3C);
    pulse(4'b0010);
    wait_req(1);
    tick();
    chk("wait_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mem_addr", 64'(mem_addr), 64'd0);
    chk("arst_overrun", 64'(ch_overrun), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) exp_dout[i] = '0;
    tick();
    mem_ack = 1'b1; mem_dout = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_rdy", 64'(ch_rdy), 64'd0);
    chk("late_ack_busy", 64'(busy), 64'd0);
    chk_dout();
    set_addr(1, 18'h3E); push(1, 18'h3E);
    pulse(4'b0010);
    wait_req(1);
    ack(1, 32'h5A5A_5A5A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
